// File: rtl/uart_cipo_rx.sv
// uart_cipo_rx: UART receive deserializer for the uart_copi_if transmitter.
// Frame: start (L), 8 data bits LSB first, stop (H); the line idles high.
// The serial input is synchronized by two flops, the start bit is confirmed
// at its mid-point, and each following bit is sampled at its mid-point.
// Received bytes go into a one-entry valid/ready holding register.
// FRAME_ERR and OVERRUN are sticky flags, cleared by ERR_CLR. When a new
// error and ERR_CLR arrive in the same cycle, the new error wins.
// Optional build macro UART_RX_PARITY_EN adds a parity bit after the data
// bits. The check is even parity, or odd parity when PARITY_ODD=1. A
// mismatch sets the sticky PARITY_ERR flag. Without the macro PARITY_ERR is
// tied to 0.
module uart_cipo_rx #(
  parameter int CLKS_PER_BIT = 1
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SER_IN,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       PARITY_ERR,
  input  logic       ERR_CLR,
  output logic       BUSY
);

  // Half a bit time positions the start-bit re-check at the bit centre.
  // Every later sample then lands one full bit time further on.
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'((HALF > 0) ? (HALF - 1) : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shreg_reg, shreg_next;
  logic            sync1_reg;
  logic            rx_s;
  logic [7:0]      rx_data_reg;
  logic            rx_valid_reg;
  logic            frame_err_reg;
  logic            overrun_reg;
  logic            tick;
  logic            deliver;
  logic            frame_bad;
  logic            overrun_set;
`ifdef UART_RX_PARITY_EN
  logic            parity_bad;
  logic            parity_err_reg;
`endif

  // Two-flop synchronizer on the asynchronous line; both flops idle high.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sync1_reg <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync1_reg <= SER_IN;
      rx_s      <= sync1_reg;
    end
  end

  // Receiver state, bit-timing counter, bit index and shift register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shreg_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shreg_reg   <= shreg_next;
    end
  end

  // Next-state logic. Every sample is taken on a tick, i.e. when the
  // down-counter reaches zero; the counter then reloads for the next bit.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shreg_next   = shreg_reg;
    deliver      = 1'b0;
    frame_bad    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad   = 1'b0;
`endif
    tick         = (cnt_reg == '0);

    case (state_reg)
      ST_IDLE: begin
        if (!rx_s) begin
          if (HALF == 0) begin
            // At one clock per bit there is no centre to wait for, so
            // the next cycle already samples data bit 0.
            state_next   = ST_DATA;
            cnt_next     = BIT_LOAD;
            bit_idx_next = '0;
          end else begin
            state_next = ST_START;
            cnt_next   = HALF_LOAD;
          end
        end
      end

      ST_START: begin
        if (tick) begin
          if (!rx_s) begin
            state_next   = ST_DATA;
            cnt_next     = BIT_LOAD;
            bit_idx_next = '0;
          end else begin
            // A glitch shorter than half a bit is a false start.
            // Drop it silently and set no flags.
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end

      ST_DATA: begin
        if (tick) begin
          shreg_next   = {rx_s, shreg_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          cnt_next     = BIT_LOAD;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          // XOR over data plus parity bit: 0 for even parity, 1 for odd.
          parity_bad = ((^shreg_reg) ^ rx_s) != PARITY_ODD;
          cnt_next   = BIT_LOAD;
          state_next = ST_STOP;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
`endif

      ST_STOP: begin
        if (tick) begin
          // The byte is delivered even if the stop bit is bad.
          deliver = 1'b1;
          if (rx_s) begin
            state_next = ST_IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = ST_BREAK;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end

      ST_BREAK: begin
        // A line held low after a framing error is one break condition,
        // not a run of new start bits.
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // A new byte is dropped only when the holding register stays full
  // through the delivery cycle.
  assign overrun_set = deliver && rx_valid_reg && !RX_READY;

  // One-entry holding register. Loading and draining can happen in the
  // same cycle, so back-to-back bytes lose no cycle.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else if (deliver && (!rx_valid_reg || RX_READY)) begin
      rx_data_reg  <= shreg_reg;
      rx_valid_reg <= 1'b1;
    end else if (rx_valid_reg && RX_READY) begin
      rx_valid_reg <= 1'b0;
    end
  end

  // Sticky error flags. A new error wins over a clear in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (frame_bad) begin
        frame_err_reg <= 1'b1;
      end else if (ERR_CLR) begin
        frame_err_reg <= 1'b0;
      end
      if (overrun_set) begin
        overrun_reg <= 1'b1;
      end else if (ERR_CLR) begin
        overrun_reg <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Sticky parity flag. A new error wins over a clear in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      parity_err_reg <= 1'b0;
    end else if (parity_bad) begin
      parity_err_reg <= 1'b1;
    end else if (ERR_CLR) begin
      parity_err_reg <= 1'b0;
    end
  end

  assign PARITY_ERR = parity_err_reg;
`else
  assign PARITY_ERR = 1'b0;
`endif

  assign RX_DATA   = rx_data_reg;
  assign RX_VALID  = rx_valid_reg;
  assign FRAME_ERR = frame_err_reg;
  assign OVERRUN   = overrun_reg;
  assign BUSY      = (state_reg != ST_IDLE);

endmodule
